// File: rtl/DPE_params.sv
// rtl/DPE_params.sv - shared DPE datapath widths and csa_resolver state encoding
package DPE_params;

  localparam int DPE_WIDTH = 16;
  localparam int DPE_CHUNK = 8;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} csa_resolver_state_t;

endpackage

// File: rtl/csa_chunk_add.sv
// rtl/csa_chunk_add.sv - combinational CHUNK-bit adder slice with carry in/out
module csa_chunk_add #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] r_o,
  output logic             cout_o
);

  assign {cout_o, r_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};

endmodule

// File: rtl/csa_resolver.sv
// rtl/csa_resolver.sv - multi-cycle carry-save to binary conversion, CHUNK bits per cycle
module csa_resolver
  import DPE_params::*;
#(
  parameter int WIDTH = DPE_WIDTH,
  parameter int CHUNK = DPE_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] s_vec,
  input  logic [WIDTH-1:0] c_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("csa_resolver: WIDTH must be an integer multiple of CHUNK");
    end
  endgenerate

  csa_resolver_state_t state_q, state_d;
  logic [NCHUNK-1:0][CHUNK-1:0] s_q, s_d, c_q, c_d, sum_q, sum_d;
  logic [KW-1:0] k_q, k_d;
  logic cy_q, cy_d, ovf_q, ovf_d;
  logic in_ready_q, out_valid_q;
  logic [CHUNK-1:0] add_r;
  logic add_cout;

  // One adder slice shared across all chunks; k_q selects the operand slices.
  csa_chunk_add #(.CHUNK(CHUNK)) u_chunk_add (
    .a_i    (s_q[k_q]),
    .b_i    (c_q[k_q]),
    .cin_i  (cy_q),
    .r_o    (add_r),
    .cout_o (add_cout)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    sum_d   = sum_q;
    k_d     = k_q;
    cy_d    = cy_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          s_d     = s_vec;
          c_d     = c_vec;
          k_d     = '0;
          cy_d    = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        sum_d[k_q] = add_r;
        cy_d       = add_cout;
        k_d        = k_q + 1'b1;
        if (k_q == KW'(NCHUNK - 1)) begin
          k_d     = '0;
          ovf_d   = add_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are registered decodes of the next state, so neither
  // depends combinationally on in_valid/out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s_q         <= '0;
      c_q         <= '0;
      sum_q       <= '0;
      k_q         <= '0;
      cy_q        <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      c_q         <= c_d;
      sum_q       <= sum_d;
      k_q         <= k_d;
      cy_q        <= cy_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_csa_resolver.sv
// tb/tb_csa_resolver.sv - directed and random checks of csa_resolver at WIDTH=16, CHUNK=4
module tb_csa_resolver;
  import DPE_params::*;

  localparam int W  = 16;
  localparam int CH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] s_vec = '0;
  logic [W-1:0] c_vec = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         ovf;

  int nvec = 0;
  int nerr = 0;

  csa_resolver #(.WIDTH(W), .CHUNK(CH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s_vec     (s_vec),
    .c_vec     (c_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a pair, wait for the accept edge, then count edges until out_valid.
  // Returns at a falling edge with the result held (out_ready low).
  task automatic txn(input string tag, input logic [W-1:0] s, input logic [W-1:0] c,
                     input logic [W-1:0] esum, input logic eovf);
    int t;
    int lat;
    s_vec = s;
    c_vec = c;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_accept"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    s_vec = 16'h5A5A;
    c_vec = 16'hA5A5;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    @(negedge clk);
    chk({tag, "_latency"}, 32'(lat), 32'd4);
    chk({tag, "_sum"}, 32'(sum), 32'(esum));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eovf));
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int cyc, last, nacc, nres, seen;
    logic [W-1:0] rs, rc;
    logic [W:0] e;
    logic [W:0] q[$];

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-BUSY aborts the transaction
    s_vec = 16'h1234;
    c_vec = 16'h0001;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("t1_busy_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("t1_abort_out_valid", 32'(out_valid), 32'd0);
    chk("t1_abort_sum", 32'(sum), 32'd0);
    chk("t1_abort_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("t1_no_result", 32'(seen), 32'd0);
    chk("t1_sum_after", 32'(sum), 32'd0);

    // Ripple across all chunks
    txn("t2_ripple", 16'h0FFF, 16'h0001, 16'h1000, 1'b0);
    consume();

    // Overflow
    txn("t3_ones", 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1);
    consume();
    txn("t3_msb", 16'h8000, 16'h8000, 16'h0000, 1'b1);
    consume();

    // Backpressure with an ignored in_valid pulse
    txn("t4_bp", 16'hABCD, 16'h1111, 16'hBCDE, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold_valid", 32'(out_valid), 32'd1);
      chk("t4_hold_sum", 32'(sum), 32'h0000BCDE);
      chk("t4_hold_ovf", 32'(ovf), 32'd0);
      chk("t4_hold_in_ready", 32'(in_ready), 32'd0);
      if (i == 3) begin
        s_vec = 16'h5555;
        c_vec = 16'h5555;
        in_valid = 1'b1;
      end
      if (i == 4) in_valid = 1'b0;
      @(negedge clk);
    end
    consume();
    chk("t4_release_in_ready", 32'(in_ready), 32'd1);
    chk("t4_release_out_valid", 32'(out_valid), 32'd0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("t4_pulse_ignored", 32'(seen), 32'd0);

    // Back-to-back traffic: 6 cycles per result
    out_ready = 1'b1;
    cyc = 0; last = -1; nacc = 0; nres = 0;
    while (nres < 50 && cyc < 1000) begin
      if (out_valid) begin
        if (q.size() == 0) chk("t5_extra_result", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("t5_sum", 32'(sum), 32'(e[W-1:0]));
          chk("t5_ovf", 32'(ovf), 32'(e[W]));
        end
        if (last >= 0) chk("t5_spacing", 32'(cyc - last), 32'd6);
        last = cyc;
        nres++;
      end
      if (in_ready) begin
        if (nacc < 50) begin
          rs = 16'($urandom);
          rc = 16'($urandom);
          s_vec = rs;
          c_vec = rc;
          in_valid = 1'b1;
          q.push_back({1'b0, rs} + {1'b0, rc});
          nacc++;
        end else in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk("t5_count", 32'(nres), 32'd50);
    @(negedge clk);

    // Random out_ready and in_valid: order, no loss, no duplication
    q.delete();
    cyc = 0; nacc = 0; nres = 0;
    while (nres < 50 && cyc < 3000) begin
      out_ready = 1'($urandom);
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("t6_extra_result", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("t6_sum", 32'(sum), 32'(e[W-1:0]));
          chk("t6_ovf", 32'(ovf), 32'(e[W]));
        end
        nres++;
      end
      if (in_ready) begin
        if (nacc < 50 && $urandom_range(0, 1) == 1) begin
          rs = 16'($urandom);
          rc = 16'($urandom);
          s_vec = rs;
          c_vec = rc;
          in_valid = 1'b1;
          q.push_back({1'b0, rs} + {1'b0, rc});
          nacc++;
        end else in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("t6_count", 32'(nres), 32'd50);
    chk("t6_queue_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
